// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared Q2.13 constants, sequencer state enum and saturation helper
//
// Purpose : common definitions for the FIR MAC sequencer and its delay line.
// Contents: FRAC/ONE/MAX/MIN Q2.13 constants, fir_state_t, saturate().
package fir_pkg;

  localparam int          FRAC = 13;
  localparam logic [15:0] ONE  = 16'h2000;
  localparam logic [15:0] MAX  = 16'h7FFF;
  localparam logic [15:0] MIN  = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_t;

  // Clamp a wide signed accumulator value into the 16-bit Q2.13 range.
  // The input is fixed at 64 bits so any ACCW can be sign-extended into it.
  function automatic logic [15:0] saturate(input logic signed [63:0] v);
    if (v > 64'sd32767)
      return MAX;
    else if (v < -64'sd32768)
      return MIN;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular Q2.13 sample buffer addressed by tap offset
//
// Purpose: holds the last TAPS input samples. The write port stores at
//          wr_ptr; the read port returns the sample written 'offset'
//          samples before the one at wr_ptr (offset 0 = newest).
// Ports  : clk, rst_n (async active-low)
//          we, wdata   - write strobe / sample written at wr_ptr
//          adv         - advance wr_ptr by one (wraps at TAPS)
//          offset      - tap offset k for the read port
//          rdata       - buf[(wr_ptr - k) mod TAPS], combinational
module fir_delay_line #(
  parameter  int TAPS = 16,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [15:0]   wdata,
  input  logic          adv,
  input  logic [AW-1:0] offset,
  output logic [15:0]   rdata
);

  logic [15:0]   mem [TAPS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else begin
      if (we)  mem[wr_ptr] <= wdata;
      if (adv) wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  // TAPS is a power of two, so the modulo is the natural AW-bit wrap.
  assign rd_addr = wr_ptr - offset;
  assign rdata   = mem[rd_addr];

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed FIR sequencer driving a shared Q2.13 multiplier
//
// Purpose: accepts one Q2.13 sample, walks all TAPS coefficients through the
//          external combinational multiplier (one pair per cycle), accumulates
//          the products and presents one filtered sample per input sample.
// Build  : define FIR_SAT_EN to clamp the output to the 16-bit range;
//          otherwise the output is acc[15:0] (wrap-around on overflow).
// Ports  : clk, rst_n (async active-low)
//          in_valid/in_ready/in_sample       - input sample handshake
//          coef_we/coef_addr/coef_data       - coefficient write (IDLE only)
//          mul_a/mul_b -> mul_p              - shared multiplier (sample, coef, product)
//          out_valid/out_ready/out_sample    - filtered sample handshake
//          busy                              - high outside IDLE
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter  int TAPS = 16,
  parameter  int ACCW = 24,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_sample,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_data,
  output logic [15:0]   mul_a,
  output logic [15:0]   mul_b,
  input  logic [15:0]   mul_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_sample,
  output logic          busy
);

  fir_state_t             state;
  fir_state_t             state_nx;
  logic [AW-1:0]          k;
  logic signed [15:0]     prod_r;
  logic signed [ACCW-1:0] acc;
  logic [15:0]            coef [TAPS];
  logic [15:0]            tap_sample;
  logic [15:0]            result;
  logic                   rst_done;
  logic                   accept;

  // Keeps in_ready low while reset is asserted and for the first edge after.
  assign accept = in_valid & in_ready;

  fir_delay_line #(.TAPS(TAPS)) u_delay_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept),
    .wdata  (in_sample),
    .adv    (state == DRAIN),
    .offset (k),
    .rdata  (tap_sample)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (k == AW'(TAPS - 1)) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state == IDLE) && rst_done;
    busy       = (state != IDLE);
    out_valid  = (state == OUT);
    out_sample = '0;
    mul_a      = '0;
    mul_b      = '0;
    if (state == MAC) begin
      mul_a = tap_sample;
      mul_b = coef[k];
    end
    if (state == OUT) out_sample = result;
  end

  // Datapath: the product of cycle k is registered and added one cycle later,
  // so the first MAC cycle adds nothing and DRAIN adds the final product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      k        <= '0;
      prod_r   <= '0;
      acc      <= '0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          acc <= '0;
          k   <= '0;
        end
        MAC: begin
          prod_r <= mul_p;
          k      <= k + 1'b1;
          if (k != '0) acc <= acc + ACCW'(prod_r);
        end
        DRAIN:   acc <= acc + ACCW'(prod_r);
        default: ;
      endcase
    end
  end

  // Coefficient register file; writes outside IDLE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (state == IDLE && coef_we) begin
      coef[coef_addr] <= coef_data;
    end
  end

`ifdef FIR_SAT_EN
  assign result = saturate({{(64 - ACCW){acc[ACCW-1]}}, acc});
`else
  logic unused_acc_hi;
  assign result        = acc[15:0];
  assign unused_acc_hi = ^acc[ACCW-1:16];
`endif

endmodule
